// File: rtl/icache_pkg.sv
// Shared icache definitions: geometry, fetch FSM states and an
// address-region helper. Imported by the fetch controller and the icache.
package icache_pkg;

  localparam int ICACHE_M = 2;
  localparam int ICACHE_N = 6;
  localparam int TAG_W = 30 - ICACHE_N - ICACHE_M;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    FILL_ACK,
    RESP
  } fetch_state_t;

  // True when the word address falls in [base, base + 2**size_log2).
  function automatic logic in_region(
    input logic [29:0] addr,
    input logic [31:0] base,
    input int          size_log2
  );
    logic [32:0] off;
    off = {1'b0, addr, 2'b00} - {1'b0, base};
    return !off[32] && ((off[31:0] >> size_log2) == 32'd0);
  endfunction

endpackage

// File: rtl/icache_fetch_ctrl_if.sv
// Fetch controller bus: IFU request/response, icache lookup/fill and
// memory read channels. master = controller, slave = environment.
interface icache_fetch_ctrl_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [29:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;

  logic        ic_req_valid;
  logic        ic_wen;
  logic [29:0] ic_addr;
  logic [31:0] ic_wdata;
  logic        ic_is_hit;
  logic        ic_resp_valid;
  logic [31:0] ic_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  modport master (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  ic_is_hit, ic_resp_valid, ic_rdata,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_data, mem_resp_err,
    output ifu_req_ready, ifu_resp_valid,
    output ifu_resp_data, ifu_resp_err,
    output ic_req_valid, ic_wen, ic_addr, ic_wdata,
    output mem_req_valid, mem_req_addr
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output ic_is_hit, ic_resp_valid, ic_rdata,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_data, mem_resp_err,
    input  ifu_req_ready, ifu_resp_valid,
    input  ifu_resp_data, ifu_resp_err,
    input  ic_req_valid, ic_wen, ic_addr, ic_wdata,
    input  mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache_fetch_ctrl_sat_counter.sv
// Saturating event counter used for fetch hit/miss statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events until saturated.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Icache fetch controller: lookup, miss refill and uncached bypass.
// Optional hit/miss counters under ICACHE_FETCH_PERF_EN.
module icache_fetch_ctrl
  import icache_pkg::*;
#(
`ifdef ICACHE_FETCH_PERF_EN
  parameter int          PERF_CNT_W    = 32,
`endif
  parameter logic [31:0] UNC_BASE      = 32'h1000_0000,
  parameter int          UNC_SIZE_LOG2 = 28
) (
  input  logic                  clock,
  input  logic                  reset_n,
`ifdef ICACHE_FETCH_PERF_EN
  output logic [PERF_CNT_W-1:0] perf_hit_cnt,
  output logic [PERF_CNT_W-1:0] perf_miss_cnt,
`endif
  icache_fetch_ctrl_if.master   bus
);

  fetch_state_t state;

  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        unc_q;

  logic        rdy_q;
  logic        ic_req_q;
  logic        wen_q;
  logic        mem_q;
  logic        resp_q;

  logic        hit;
  logic        req_unc;

  assign hit = bus.ic_resp_valid & bus.ic_is_hit;
  assign req_unc = in_region(bus.ifu_req_addr, UNC_BASE,
                             UNC_SIZE_LOG2);

  // Fetch FSM; every strobe is a flop set on entry to its state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      unc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      ic_req_q <= 1'b0;
      wen_q    <= 1'b0;
      mem_q    <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rdy_q && bus.ifu_req_valid) begin
            rdy_q  <= 1'b0;
            addr_q <= bus.ifu_req_addr;
            unc_q  <= req_unc;
            err_q  <= 1'b0;
            if (req_unc) begin
              state <= MEM_REQ;
              mem_q <= 1'b1;
            end else begin
              state    <= LOOKUP;
              ic_req_q <= 1'b1;
            end
          end else begin
            rdy_q <= 1'b1;
          end
        end
        LOOKUP: begin
          ic_req_q <= 1'b0;
          if (hit) begin
            data_q <= bus.ic_rdata;
            state  <= RESP;
            resp_q <= 1'b1;
          end else begin
            state <= MEM_REQ;
            mem_q <= 1'b1;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            mem_q <= 1'b0;
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            data_q <= bus.mem_resp_data;
            err_q  <= bus.mem_resp_err;
            if (bus.mem_resp_err || unc_q) begin
              state  <= RESP;
              resp_q <= 1'b1;
            end else begin
              state <= FILL;
              wen_q <= 1'b1;
            end
          end
        end
        FILL: begin
          wen_q <= 1'b0;
          state <= FILL_ACK;
        end
        FILL_ACK: begin
          if (bus.ic_resp_valid) begin
            state  <= RESP;
            resp_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.ifu_resp_ready) begin
            resp_q <= 1'b0;
            rdy_q  <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          ic_req_q <= 1'b0;
          wen_q    <= 1'b0;
          mem_q    <= 1'b0;
          resp_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready  = rdy_q;
  assign bus.ifu_resp_valid = resp_q;
  assign bus.ifu_resp_data  = data_q;
  assign bus.ifu_resp_err   = err_q;
  assign bus.ic_req_valid   = ic_req_q;
  assign bus.ic_wen         = wen_q;
  assign bus.ic_addr        = addr_q;
  assign bus.ic_wdata       = data_q;
  assign bus.mem_req_valid  = mem_q;
  assign bus.mem_req_addr   = {addr_q, 2'b00};

`ifdef ICACHE_FETCH_PERF_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = (state == LOOKUP) & hit;
  assign miss_inc = (state == LOOKUP) & ~hit;

  sat_counter #(.W(PERF_CNT_W)) u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (hit_inc),
    .count   (perf_hit_cnt)
  );

  sat_counter #(.W(PERF_CNT_W)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (miss_inc),
    .count   (perf_miss_cnt)
  );
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Testbench for icache_fetch_ctrl: icache and memory models plus a
// response scoreboard; directed fetches with hand-computed results.
module tb_icache_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_fetch_ctrl_if bus();

`ifdef ICACHE_FETCH_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_fetch_ctrl dut (
    .clock         (clk),
    .reset_n       (rst_n),
`ifdef ICACHE_FETCH_PERF_EN
    .perf_hit_cnt  (hit_cnt),
    .perf_miss_cnt (miss_cnt),
`endif
    .bus           (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- icache model (direct mapped on addr[7:0])
  logic [29:0] tagm [256];
  logic [31:0] datm [256];
  logic        vm   [256];
  logic        cache_ok = 1'b0;
  logic        wen_d = 1'b0;
  logic        fill_ack = 1'b0;
  int          n_lookup = 0;
  int          n_fill = 0;
  int          n_both = 0;
  logic [29:0] fill_addr = '0;
  logic [31:0] fill_data = '0;
  logic [7:0]  idx;

  assign idx = bus.ic_addr[7:0];

  // Outside a lookup the hit/data lines carry junk on purpose.
  always_comb begin
    bus.ic_is_hit = 1'b1;
    bus.ic_rdata  = 32'hBAD0_BAD0;
    if (bus.ic_req_valid) begin
      bus.ic_is_hit = vm[idx] && (tagm[idx] == bus.ic_addr);
      bus.ic_rdata  = datm[idx];
    end
    bus.ic_resp_valid = bus.ic_req_valid | fill_ack;
  end

  always @(negedge clk) begin
    if (!cache_ok) begin
      for (int i = 0; i < 256; i++) vm[i] <= 1'b0;
      cache_ok <= 1'b1;
    end
    wen_d    <= bus.ic_wen;
    fill_ack <= wen_d;
    if (bus.ic_req_valid) n_lookup <= n_lookup + 1;
    if (bus.ic_wen && bus.ic_req_valid) n_both <= n_both + 1;
    if (bus.ic_wen) begin
      n_fill    <= n_fill + 1;
      fill_addr <= bus.ic_addr;
      fill_data <= bus.ic_wdata;
      tagm[idx] <= bus.ic_addr;
      datm[idx] <= bus.ic_wdata;
      vm[idx]   <= 1'b1;
    end
  end

  // ---------------- memory model
  int          mem_d = 1;
  int          mem_stall = 0;
  logic [31:0] mem_data = '0;
  logic        mem_err = 1'b0;
  int          stall_cnt = 0;
  int          resp_cnt = 0;
  logic        pend = 1'b0;
  int          n_memreq = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] hold_addr = '0;

  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.mem_resp_err   = 1'b0;
  end

  always @(negedge clk) begin
    bus.mem_resp_valid <= 1'b0;
    if (pend) begin
      if (resp_cnt == 1) begin
        bus.mem_resp_valid <= 1'b1;
        bus.mem_resp_data  <= mem_data;
        bus.mem_resp_err   <= mem_err;
        pend <= 1'b0;
      end
      resp_cnt <= resp_cnt - 1;
    end
    if (bus.mem_req_valid) begin
      if (stall_cnt < mem_stall) begin
        bus.mem_req_ready <= 1'b0;
        stall_cnt <= stall_cnt + 1;
        hold_addr <= bus.mem_req_addr;
        if (stall_cnt > 0)
          check("mem_addr_hold", bus.mem_req_addr, hold_addr);
        check("ready_in_mem_stall",
              32'(bus.ifu_req_ready), 32'd0);
      end else begin
        bus.mem_req_ready <= 1'b1;
        stall_cnt <= 0;
        pend      <= 1'b1;
        resp_cnt  <= mem_d;
        n_memreq  <= n_memreq + 1;
        mem_addr  <= bus.mem_req_addr;
      end
    end else begin
      bus.mem_req_ready <= 1'b0;
      stall_cnt <= 0;
    end
  end

  // ---------------- scoreboard
  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          rs_cfg = 0;
  int          rs_cnt = 0;
  logic        seen = 1'b0;
  logic [31:0] seen_data = '0;
  logic        seen_err = 1'b0;

  initial bus.ifu_resp_ready = 1'b0;

  always @(negedge clk) begin
    if (rst_n && bus.ifu_resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
        bus.ifu_resp_ready <= 1'b1;
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - exp_q[0].acc),
                32'(exp_q[0].lat));
          seen      <= 1'b1;
          seen_data <= bus.ifu_resp_data;
          seen_err  <= bus.ifu_resp_err;
        end else begin
          check("resp_data_hold", bus.ifu_resp_data, seen_data);
          check("resp_err_hold", 32'(bus.ifu_resp_err),
                32'(seen_err));
        end
        if (rs_cnt < rs_cfg) begin
          bus.ifu_resp_ready <= 1'b0;
          rs_cnt <= rs_cnt + 1;
          check("ready_in_resp_stall",
                32'(bus.ifu_req_ready), 32'd0);
        end else begin
          bus.ifu_resp_ready <= 1'b1;
          rs_cnt <= 0;
          seen   <= 1'b0;
          if (exp_q[0].chk_data)
            check("resp_data", bus.ifu_resp_data, exp_q[0].data);
          check("resp_err", 32'(bus.ifu_resp_err),
                32'(exp_q[0].err));
          void'(exp_q.pop_front());
        end
      end
    end else begin
      bus.ifu_resp_ready <= 1'b0;
      seen   <= 1'b0;
      rs_cnt <= 0;
    end
  end

  // ---------------- stimulus
  task automatic set_mem(input int d, input logic [31:0] data,
                         input logic err, input int stall);
    mem_d     = d;
    mem_data  = data;
    mem_err   = err;
    mem_stall = stall;
  endtask

  task automatic issue(input logic [29:0] a, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!bus.ifu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ifu_req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = a;
      ok = 1'b1;
    end
  endtask

  task automatic fetch(input logic [29:0] a, input logic [31:0] d,
                       input logic e, input logic cd,
                       input int lat);
    exp_t x;
    logic ok;
    int   n;
    issue(a, ok);
    if (ok) begin
      x.data = d;
      x.err  = e;
      x.chk_data = cd;
      x.lat  = lat;
      x.acc  = cyc;
      exp_q.push_back(x);
      @(negedge clk);
      bus.ifu_req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) begin
        check("resp_timeout", 32'd0, 32'd1);
        exp_q.delete();
      end
      @(negedge clk);
    end
  endtask

  int m0, f0, l0, n;
  logic ok;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_addr  = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.ifu_req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.ifu_resp_valid), 32'd0);
    check("rst_ic_req", 32'(bus.ic_req_valid), 32'd0);
    check("rst_ic_wen", 32'(bus.ic_wen), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_addr", bus.mem_req_addr, 32'd0);
    check("rst_resp_data", bus.ifu_resp_data, 32'd0);
    rst_n = 1'b1;

    // cold miss
    set_mem(3, 32'hDEAD_BEEF, 1'b0, 0);
    m0 = n_memreq; f0 = n_fill;
    fetch(30'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 8);
    check("miss_fills", 32'(n_fill - f0), 32'd1);
    check("miss_fill_addr", 32'(fill_addr), 32'h100);
    check("miss_fill_data", fill_data, 32'hDEAD_BEEF);
    check("miss_memreqs", 32'(n_memreq - m0), 32'd1);
    check("miss_mem_addr", mem_addr, 32'h400);

    // refetch hits
    m0 = n_memreq; l0 = n_lookup;
    fetch(30'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 2);
    check("hit_memreqs", 32'(n_memreq - m0), 32'd0);
    check("hit_lookups", 32'(n_lookup - l0), 32'd1);
`ifdef ICACHE_FETCH_PERF_EN
    check("perf_hit", hit_cnt, 32'd1);
    check("perf_miss", miss_cnt, 32'd1);
`endif

    // conflict pair on index 0
    set_mem(1, 32'h1234_5678, 1'b0, 0);
    f0 = n_fill;
    fetch(30'h500, 32'h1234_5678, 1'b0, 1'b1, 6);
    check("conf_fill_addr", 32'(fill_addr), 32'h500);
    set_mem(2, 32'hDEAD_BEEF, 1'b0, 0);
    m0 = n_memreq;
    fetch(30'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 7);
    check("conf_remiss", 32'(n_memreq - m0), 32'd1);
    check("conf_fills", 32'(n_fill - f0), 32'd2);

    // uncached bypass, both region edges
    set_mem(2, 32'hCAFE_F00D, 1'b0, 0);
    l0 = n_lookup; f0 = n_fill;
    fetch(30'h0400_0000, 32'hCAFE_F00D, 1'b0, 1'b1, 4);
    set_mem(2, 32'h0F0F_0F0F, 1'b0, 0);
    fetch(30'h07FF_FFFF, 32'h0F0F_0F0F, 1'b0, 1'b1, 4);
    check("unc_lookups", 32'(n_lookup - l0), 32'd0);
    check("unc_fills", 32'(n_fill - f0), 32'd0);
    check("unc_mem_addr", mem_addr, 32'h1FFF_FFFC);
    set_mem(2, 32'hA5A5_5A5A, 1'b0, 0);
    fetch(30'h0800_0010, 32'hA5A5_5A5A, 1'b0, 1'b1, 7);
    check("above_unc_cached", 32'(n_fill - f0), 32'd1);

    // memory error: no fill, next fetch misses
    set_mem(2, 32'h0000_0BAD, 1'b1, 0);
    f0 = n_fill;
    fetch(30'h204, 32'h0, 1'b1, 1'b0, 5);
    check("err_no_fill", 32'(n_fill - f0), 32'd0);
    set_mem(2, 32'h1111_2222, 1'b0, 0);
    m0 = n_memreq;
    fetch(30'h204, 32'h1111_2222, 1'b0, 1'b1, 7);
    check("err_remiss", 32'(n_memreq - m0), 32'd1);

    // backpressure on both sides
    set_mem(1, 32'h3333_4444, 1'b0, 4);
    rs_cfg = 3;
    fetch(30'h308, 32'h3333_4444, 1'b0, 1'b1, 10);
    rs_cfg = 0;
    check("bp_mem_addr", mem_addr, 32'hC20);

    // reset while waiting on memory
    set_mem(6, 32'h5555_AAAA, 1'b0, 0);
    m0 = n_memreq;
    issue(30'h700, ok);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    n = 0;
    while (n_memreq == m0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_memreq", 32'(n_memreq - m0), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(bus.mem_req_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus.ifu_req_ready), 32'd0);
    check("mid_rst_resp_valid", 32'(bus.ifu_resp_valid), 32'd0);
    check("mid_rst_ic", 32'({bus.ic_req_valid, bus.ic_wen}),
          32'd0);
    check("mid_rst_mem_addr", bus.mem_req_addr, 32'd0);
    check("mid_rst_ic_addr", 32'(bus.ic_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m0 = n_memreq;
    fetch(30'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 2);
    repeat (4) @(negedge clk);
    check("post_rst_memreqs", 32'(n_memreq - m0), 32'd0);
`ifdef ICACHE_FETCH_PERF_EN
    check("perf_hit_post_rst", hit_cnt, 32'd1);
    check("perf_miss_post_rst", miss_cnt, 32'd0);
`endif

    check("wen_and_req", 32'(n_both), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
